seven_segment_scanner: RTL and testbench

Time-multiplexed driver for an N-digit common-anode seven-segment display with hexadecimal decode. It accepts a packed word of 4-bit digit values and scans one digit at a time at a programmable dwell rate. Updates are frame-synchronous so the display never tears mid-scan, and each digit slot has a one-cycle anode dead time. It is the clocked, multi-digit successor to the single-digit combinational decoder and sits between the arithmetic/result datapath and the board's segment/anode pins.

---
 rtl/seven_segment_scanner_if.sv | 31 +++
 rtl/seven_segment_scanner.sv | 193 +++++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_scanner_if
// Description : Data, control and pin-side signal bundle of the
//               seven-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_segment_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] dataIN;
    logic                    dataVALID;
    logic [NUM_DIGITS-1:0]   blankIN;
    logic [NUM_DIGITS-1:0]   dpIN;
    logic                    enableIN;
    logic [6:0]              segOUT;
    logic                    dpOUT;
    logic [NUM_DIGITS-1:0]   anodeOUT;
    logic                    frameDONE;

    modport master (
        output dataIN, dataVALID, blankIN, dpIN, enableIN,
        input  segOUT, dpOUT, anodeOUT, frameDONE
    );

    modport slave (
        input  dataIN, dataVALID, blankIN, dpIN, enableIN,
        output segOUT, dpOUT, anodeOUT, frameDONE
    );
endinterface
`default_nettype wire

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_scanner
// Description : Time-multiplexed N-digit hex seven-segment driver with
//               frame-synchronous updates and per-slot anode dead time.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_AN  = 1,
    parameter int LZ_BLANK       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    seven_segment_scanner_if.slave  bus
);

    localparam int c_DW    = 4 * NUM_DIGITS;
    localparam int c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0]            c_SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
    localparam logic                  c_DP_OFF  = (ACTIVE_LOW_SEG != 0);
    localparam logic [NUM_DIGITS-1:0] c_AN_OFF  = (ACTIVE_LOW_AN != 0) ? '1 : '0;

    // ------------------------------------------------------------------
    // Scan position
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic               w_slot_end;
    logic               w_boundary;

    assign w_slot_end = (r_cnt == c_CNT_LAST);
    assign w_boundary = w_slot_end && (r_idx == c_IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pending and display registers
    // ------------------------------------------------------------------
    logic [c_DW-1:0]       r_pend_data;
    logic [NUM_DIGITS-1:0] r_pend_blank;
    logic [NUM_DIGITS-1:0] r_pend_dp;
    logic                  r_pend_flag;

    logic [c_DW-1:0]       r_disp_data;
    logic [NUM_DIGITS-1:0] r_disp_blank;
    logic [NUM_DIGITS-1:0] r_disp_dp;

    // A strobe landing on the boundary itself is the newest data, so it
    // goes straight to the display and any older pending word is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_data  <= '0;
            r_pend_blank <= '0;
            r_pend_dp    <= '0;
            r_pend_flag  <= 1'b0;
            r_disp_data  <= '0;
            r_disp_blank <= '0;
            r_disp_dp    <= '0;
        end else if (w_boundary) begin
            r_pend_flag <= 1'b0;
            if (bus.dataVALID) begin
                r_disp_data  <= bus.dataIN;
                r_disp_blank <= bus.blankIN;
                r_disp_dp    <= bus.dpIN;
            end else if (r_pend_flag) begin
                r_disp_data  <= r_pend_data;
                r_disp_blank <= r_pend_blank;
                r_disp_dp    <= r_pend_dp;
            end
        end else if (bus.dataVALID) begin
            r_pend_data  <= bus.dataIN;
            r_pend_blank <= bus.blankIN;
            r_pend_dp    <= bus.dpIN;
            r_pend_flag  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Digit decode
    // ------------------------------------------------------------------
    function automatic logic [6:0] f_hex_to_seg(input logic [3:0] i_val);
        logic [6:0] v_seg;
        case (i_val)
            4'h0:    v_seg = 7'b1000000;
            4'h1:    v_seg = 7'b1111001;
            4'h2:    v_seg = 7'b0100100;
            4'h3:    v_seg = 7'b0110000;
            4'h4:    v_seg = 7'b0011001;
            4'h5:    v_seg = 7'b0010010;
            4'h6:    v_seg = 7'b0000010;
            4'h7:    v_seg = 7'b1111000;
            4'h8:    v_seg = 7'b0000000;
            4'h9:    v_seg = 7'b0010000;
            4'hA:    v_seg = 7'b0001000;
            4'hB:    v_seg = 7'b0000011;
            4'hC:    v_seg = 7'b1000110;
            4'hD:    v_seg = 7'b0100001;
            4'hE:    v_seg = 7'b0000110;
            default: v_seg = 7'b0001110;
        endcase
        return v_seg;
    endfunction

    logic [NUM_DIGITS-1:0] w_dig_zero;
    logic [NUM_DIGITS-1:0] w_upper_zero;
    logic [NUM_DIGITS-1:0] w_an_onehot;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_dig_zero[gi]  = (r_disp_data[4*gi +: 4] == 4'h0);
            assign w_an_onehot[gi] = (r_idx == c_IDX_W'(gi));
        end
    endgenerate

    // w_upper_zero[i]: digit i and every more-significant digit are zero.
    always_comb begin
        w_upper_zero = '0;
        w_upper_zero[NUM_DIGITS-1] = w_dig_zero[NUM_DIGITS-1];
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            w_upper_zero[i] = w_dig_zero[i] && w_upper_zero[i+1];
        end
    end

    logic [3:0]            w_digit;
    logic                  w_lz_blank;
    logic                  w_blank;
    logic [6:0]            w_seg_al;
    logic [6:0]            w_seg;
    logic                  w_dp;
    logic [NUM_DIGITS-1:0] w_an;

    assign w_digit    = r_disp_data[{r_idx, 2'b00} +: 4];
    assign w_lz_blank = (LZ_BLANK != 0) && (r_idx != '0) && w_upper_zero[r_idx];
    assign w_blank    = r_disp_blank[r_idx] || w_lz_blank;
    assign w_seg_al   = w_blank ? 7'h7F : f_hex_to_seg(w_digit);
    assign w_seg      = (ACTIVE_LOW_SEG != 0) ? w_seg_al : ~w_seg_al;
    assign w_dp       = (ACTIVE_LOW_SEG != 0) ? ~r_disp_dp[r_idx] : r_disp_dp[r_idx];

    // First cycle of every slot is anode dead time to avoid ghosting.
    always_comb begin
        w_an = c_AN_OFF;
        if (bus.enableIN && (r_cnt != '0)) begin
            w_an = (ACTIVE_LOW_AN != 0) ? ~w_an_onehot : w_an_onehot;
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg        <= c_SEG_OFF;
            r_dp         <= c_DP_OFF;
            r_an         <= c_AN_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= w_seg;
            r_dp         <= w_dp;
            r_an         <= w_an;
            r_frame_done <= w_boundary;
        end
    end

    assign bus.segOUT    = r_seg;
    assign bus.dpOUT     = r_dp;
    assign bus.anodeOUT  = r_an;
    assign bus.frameDONE = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_scanner
// Description : Scoreboard bench for seven_segment_scanner against a
//               frame-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scanner;

    localparam int c_ND = 4;
    localparam int c_RD = 4;
    localparam int c_FR = c_ND * c_RD;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seven_segment_scanner_if #(.NUM_DIGITS(c_ND)) u_if ();

    seven_segment_scanner #(
        .NUM_DIGITS     (c_ND),
        .REFRESH_DIV    (c_RD),
        .ACTIVE_LOW_SEG (1),
        .ACTIVE_LOW_AN  (1),
        .LZ_BLANK       (1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    typedef struct {
        int         n;
        logic [15:0] d;
        logic [3:0]  b;
        logic [3:0]  p;
    } strobe_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    strobe_t strobes[$];
    exp_t    expq[$];
    int      n      = 0;
    int      errors = 0;
    int      checks = 0;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // A frame shows the newest strobe issued before that frame began.
    task automatic step(input bit r, input bit v, input logic [15:0] d,
                        input logic [3:0] b, input logic [3:0] p, input bit en);
        exp_t        e;
        strobe_t     s;
        int          cnt, idx, start;
        logic [15:0] cd;
        logic [3:0]  cb, cp, dig;
        bit          lz;
        rst            = r;
        u_if.dataVALID = v;
        u_if.dataIN    = d;
        u_if.blankIN   = b;
        u_if.dpIN      = p;
        u_if.enableIN  = en;
        if (r) begin
            e.an  = 4'hF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
            e.fd  = 1'b0;
            strobes.delete();
            n = 0;
        end else begin
            cnt   = n % c_RD;
            idx   = (n / c_RD) % c_ND;
            start = (n / c_FR) * c_FR;
            cd = '0; cb = '0; cp = '0;
            foreach (strobes[k]) begin
                if (strobes[k].n < start) begin
                    cd = strobes[k].d; cb = strobes[k].b; cp = strobes[k].p;
                end
            end
            dig   = cd[idx*4 +: 4];
            lz    = (idx != 0) && ((cd >> (4 * idx)) == 16'h0);
            e.seg = (cb[idx] || lz) ? 7'h7F : hex_tab[dig];
            e.dp  = ~cp[idx];
            e.an  = (en && cnt != 0) ? ~(4'b0001 << idx) : 4'hF;
            e.fd  = ((n % c_FR) == c_FR - 1);
            if (v) begin
                s.n = n; s.d = d; s.b = b; s.p = p;
                strobes.push_back(s);
            end
            n++;
        end
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit en);
        step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom), en);
    endtask

    task automatic strobe(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
        step(1'b0, 1'b1, d, b, p, 1'b1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: compares the outputs of every edge against the queued model.
    always @(negedge clk) begin : mon
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("anodeOUT",  32'(u_if.anodeOUT),  32'(e.an));
            chk("segOUT",    32'(u_if.segOUT),    32'(e.seg));
            chk("dpOUT",     32'(u_if.dpOUT),     32'(e.dp));
            chk("frameDONE", 32'(u_if.frameDONE), 32'(e.fd));
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        bit          r, v, en;
        logic [15:0] d;
        repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b1);
        repeat (2 * c_FR) idle(1'b1);

        // Mid-frame strobe
        while (n % c_FR != 6) idle(1'b1);
        strobe(16'h1A2F, 4'h0, 4'h0);
        repeat (2 * c_FR) idle(1'b1);

        // Two strobes in one frame, last wins
        while (n % c_FR != 2) idle(1'b1);
        strobe(16'h1111, 4'h0, 4'h0);
        repeat (3) idle(1'b1);
        strobe(16'h2222, 4'h0, 4'h0);
        repeat (2 * c_FR) idle(1'b1);

        // Pending present, then strobe on the boundary cycle
        while (n % c_FR != 5) idle(1'b1);
        strobe(16'h3333, 4'h0, 4'h0);
        while (n % c_FR != c_FR - 1) idle(1'b1);
        strobe(16'h4567, 4'h0, 4'h0);
        repeat (2 * c_FR) idle(1'b1);

        // Leading-zero suppression, then forced blank and decimal point
        strobe(16'h0050, 4'h0, 4'h0);
        repeat (2 * c_FR) idle(1'b1);
        strobe(16'h0050, 4'b0001, 4'b0100);
        repeat (2 * c_FR) idle(1'b1);

        // Disabled frame, reset mid-slot, restart
        strobe(16'h9876, 4'h0, 4'h3);
        repeat (c_FR) idle(1'b0);
        while (n % c_RD != 2) idle(1'b0);
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        repeat (2 * c_FR) idle(1'b1);

        // Randomized traffic
        repeat (1500) begin
            r  = ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 7) == 0);
            en = ($urandom_range(0, 9) != 0);
            d  = 16'($urandom) >> (4 * $urandom_range(0, 4));
            step(r, v, d, 4'($urandom) & 4'($urandom), 4'($urandom), en);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
